// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, PC command encodings, fetch FSM states and FIFO entry type
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam logic [1:0] PC_CMD_HOLD = 2'b00;
    localparam logic [1:0] PC_CMD_INC = 2'b01;
    localparam logic [1:0] PC_CMD_LOAD = 2'b10;
    localparam logic [1:0] PC_CMD_CLR = 2'b11;
    typedef enum logic [2:0] {FS_INIT, FS_SETTLE, FS_REQ, FS_WAIT, FS_STALL} fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: instruction-memory read bus and decode-side instruction stream
interface instr_fetch_ctrl_if;
    import cpu_pkg::*;
    logic imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic imem_gnt;
    logic imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic ir_valid;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic ir_ready;
    modport master (
        output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        input imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );
    modport slave (
        input imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead prefetch FIFO with registered head, same-cycle push/pop and flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INSTR_W-1:0] in_data,
    output logic [AW:0] count,
    output logic head_valid,
    output logic [INSTR_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    fetch_entry_t mem [DEPTH];
    fetch_entry_t head, head_nxt, in_e;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0] cnt_nxt;
    logic do_push, do_pop;
    always_comb begin
        in_e = '{pc: in_pc, data: in_data};
        do_pop = pop & (count != '0) & ~flush;
        do_push = push & ~flush & ((count != FULL) | do_pop);
        rd_nxt = rd_ptr + AW'(do_pop);
        cnt_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // the new head bypasses storage when it is the word being written this cycle
        head_nxt = (do_push && wr_ptr == rd_nxt) ? in_e : mem[rd_nxt];
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= in_e;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            head_valid <= 1'b0;
            head <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= cnt_nxt;
            head_valid <= cnt_nxt != '0;
            if (cnt_nxt != '0) head <= head_nxt;
        end
    assign head_data = head.data;
    assign head_pc = head.pc;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: drives the PC command port and fetches words over req/gnt/rvalid into a prefetch FIFO
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic [1:0] pc_cmd,
    output logic [ADDR_W-1:0] pc_target,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic restart,
    instr_fetch_ctrl_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    fetch_state_t state, state_nxt;
    logic outstanding, drop, out_nxt, drop_nxt;
    logic flush, push, pop, req, gnt_ok;
    logic [1:0] cmd;
    logic [AW:0] count, cnt_after;
    logic [ADDR_W-1:0] req_addr;
    always_comb begin
        flush = restart | redirect_valid;
        pop = bus.ir_valid & bus.ir_ready & ~flush;
        push = (state == FS_WAIT) & bus.imem_rvalid & ~drop & ~flush;
        cnt_after = count + (AW+1)'(push) - (AW+1)'(pop);
        // a dropped response must come back before a new request may be granted
        req = (state == FS_REQ) & ~drop & ~flush;
        gnt_ok = req & bus.imem_gnt;
        cmd = restart ? PC_CMD_CLR : redirect_valid ? PC_CMD_LOAD :
              (state == FS_INIT) ? PC_CMD_CLR : gnt_ok ? PC_CMD_INC : PC_CMD_HOLD;
        out_nxt = ~flush & (gnt_ok | (outstanding & ~bus.imem_rvalid));
        drop_nxt = (drop | (flush & outstanding)) & ~bus.imem_rvalid;
        state_nxt = state;
        if (flush) state_nxt = FS_SETTLE;
        else
            case (state)
                FS_INIT: state_nxt = FS_SETTLE;
                FS_SETTLE: state_nxt = (count < FULL) ? FS_REQ : FS_STALL;
                FS_REQ: state_nxt = gnt_ok ? FS_WAIT : FS_REQ;
                FS_WAIT: state_nxt = !bus.imem_rvalid ? FS_WAIT : (cnt_after < FULL) ? FS_REQ : FS_STALL;
                FS_STALL: state_nxt = pop ? FS_REQ : FS_STALL;
                default: state_nxt = FS_INIT;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= FS_INIT;
            outstanding <= 1'b0;
            drop <= 1'b0;
            req_addr <= '0;
        end else begin
            state <= state_nxt;
            outstanding <= out_nxt;
            drop <= drop_nxt;
            if (gnt_ok) req_addr <= pc_addr;
        end
    // the PC has no reset of its own, so nothing reaches it while we are held in reset
    assign pc_cmd = rst_n ? cmd : PC_CMD_HOLD;
    assign pc_target = (rst_n & ~restart & redirect_valid) ? redirect_addr : '0;
    assign bus.imem_req = req;
    assign bus.imem_addr = req ? pc_addr : '0;
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(flush),
        .in_pc(req_addr),
        .in_data(bus.imem_rdata),
        .count(count),
        .head_valid(bus.ir_valid),
        .head_data(bus.ir_data),
        .head_pc(bus.ir_pc)
    );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: PC register, memory and decode models with a sequential-stream scoreboard
module tb_instr_fetch_ctrl;
    import cpu_pkg::*;
    logic clk = 0, rst_n = 0, restart = 0, redirect_valid = 0;
    logic [15:0] redirect_addr = 0, pc_q = 16'h1234, pc_target;
    logic [1:0] pc_cmd;
    int n_tests = 0, n_fail = 0, cyc_n = 0, pops = 0, gnts = 0, waited = 0, cur_delay = 0;
    int gmin = 0, gmax = 0, lmin = 1, lmax = 1, g0, nw;
    logic [15:0] exp_pc = 0, prev_addr = 0;
    logic chk_fl = 0, hold_prev = 0, c_fl, c_req, c_gnt;
    logic [15:0] pend_a[$];
    int pend_due[$];

    instr_fetch_ctrl_if bus();
    instr_fetch_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_cmd(pc_cmd), .pc_target(pc_target), .pc_addr(pc_q),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .restart(restart), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic rs, input logic rd, input logic [15:0] a);
        at_edge();
        restart = rs;
        redirect_valid = rd;
        redirect_addr = a;
        at_edge();
        restart = 0;
        redirect_valid = 0;
    endtask

    task automatic wait_pops(input int n);
        int target;
        target = pops + n;
        for (int i = 0; i < 300 && pops < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (pops < target) check("pop_timeout", pops, target);
    endtask

    always @(posedge clk)
        case (pc_cmd)
            PC_CMD_INC: pc_q <= pc_q + 16'd1;
            PC_CMD_LOAD: pc_q <= pc_target;
            PC_CMD_CLR: pc_q <= 16'h0;
            default: ;
        endcase

    initial begin
        bus.imem_gnt = 0;
        bus.imem_rvalid = 0;
        bus.imem_rdata = 0;
        forever begin
            @(posedge clk);
            cyc_n++;
            #2;
            bus.imem_rvalid = pend_a.size() != 0 && cyc_n >= pend_due[0];
            bus.imem_rdata = bus.imem_rvalid ? word_at(pend_a[0]) : 16'($urandom);
            bus.imem_gnt = bus.imem_req && pend_a.size() == 0 && waited >= cur_delay;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            c_fl = restart | redirect_valid;
            c_req = bus.imem_req;
            c_gnt = bus.imem_gnt;
            if (chk_fl) check("ir_valid_after_flush", bus.ir_valid, 0);
            chk_fl = c_fl;
            if (c_fl) begin
                check("flush_cmd", pc_cmd, restart ? PC_CMD_CLR : PC_CMD_LOAD);
                if (!restart) check("flush_target", pc_target, redirect_addr);
                check("flush_req", c_req, 0);
                exp_pc = restart ? 16'h0 : redirect_addr;
            end else begin
                if (bus.ir_valid && bus.ir_ready) begin
                    check("ir_pc", bus.ir_pc, exp_pc);
                    check("ir_data", bus.ir_data, word_at(exp_pc));
                    exp_pc++;
                    pops++;
                end
                check("inc_only_on_gnt", pc_cmd == PC_CMD_INC, c_req && c_gnt);
                if (c_req) begin
                    check("imem_addr", bus.imem_addr, pc_q);
                    check("one_outstanding", pend_a.size(), 0);
                end
                if (hold_prev) begin
                    check("req_held", c_req, 1);
                    check("addr_held", bus.imem_addr, prev_addr);
                end
            end
            hold_prev = !c_fl && c_req && !c_gnt;
            prev_addr = bus.imem_addr;
            if (c_req && c_gnt) begin
                pend_a.push_back(bus.imem_addr);
                pend_due.push_back(cyc_n + int'($urandom_range(lmin, lmax)));
                gnts++;
                waited = 0;
                cur_delay = $urandom_range(gmin, gmax);
            end else if (c_req) waited++;
            if (bus.imem_rvalid) begin
                void'(pend_a.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    initial begin
        bus.ir_ready = 1;
        redirect_valid = 1;
        redirect_addr = 16'h5555;
        repeat (3) @(negedge clk);
        check("rst_pc_cmd", pc_cmd, 0);
        check("rst_pc_target", pc_target, 0);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_ir_valid", bus.ir_valid, 0);
        check("rst_ir_pc", bus.ir_pc, 0);
        redirect_valid = 0;
        redirect_addr = 0;
        at_edge();
        rst_n = 1;
        @(negedge clk);
        check("init_clr", pc_cmd, PC_CMD_CLR);
        @(negedge clk);
        check("settle_hold", pc_cmd, PC_CMD_HOLD);
        @(negedge clk);
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 0);
        check("first_inc", pc_cmd, PC_CMD_INC);
        wait_pops(3);

        lmin = 4;
        lmax = 4;
        nw = 0;
        for (int i = 0; i < 50 && nw == 0; i++) begin
            @(negedge clk);
            #1;
            if (pend_a.size() != 0 && bus.imem_req == 0) nw = 1;
        end
        check("wait_for_grant", nw, 1);
        pulse(0, 1, 16'h0040);
        lmin = 1;
        lmax = 1;
        wait_pops(3);

        at_edge();
        bus.ir_ready = 0;
        pulse(0, 1, 16'h00A0);
        g0 = gnts;
        repeat (20) at_edge();
        check("stall_grants", gnts - g0, 4);
        check("stall_req", bus.imem_req, 0);
        check("stall_head_valid", bus.ir_valid, 1);
        check("stall_head_pc", bus.ir_pc, 16'h00A0);
        at_edge();
        bus.ir_ready = 1;
        wait_pops(6);

        pulse(1, 1, 16'h0123);
        wait_pops(3);

        gmin = 5;
        gmax = 5;
        at_edge();
        redirect_valid = 1;
        redirect_addr = 16'h0200;
        waited = 0;
        cur_delay = 5;
        at_edge();
        redirect_valid = 0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) break;
            if (bus.imem_req) nw++;
        end
        check("gnt_wait_cycles", nw, 5);
        wait_pops(3);
        gmin = 0;
        gmax = 0;

        pulse(0, 1, 16'hFFFE);
        wait_pops(3);

        gmax = 3;
        lmax = 3;
        for (int i = 0; i < 1000; i++) begin
            at_edge();
            bus.ir_ready = $urandom_range(0, 3) != 0;
            restart = $urandom_range(0, 99) == 0;
            redirect_valid = $urandom_range(0, 29) == 0;
            redirect_addr = 16'($urandom);
        end
        at_edge();
        restart = 0;
        redirect_valid = 0;
        bus.ir_ready = 1;
        wait_pops(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
